// File: rtl/sync_fifo_pkt_drain.sv
// Read-side drain for the 48-bit {src,dst,data} packet FIFO: pops one entry,
// then serialises it MSB-first as six bytes onto a valid/ready byte link.
module sync_fifo_pkt_drain #(
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_src,
  input  logic [7:0]       fifo_dst,
  input  logic [31:0]      fifo_data,
  output logic             fifo_rd,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  output logic             tx_sop,
  output logic             tx_eop,
  input  logic             tx_ready,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_CAP,
    S_SEND,
    S_GAP
  } state_e;

  localparam logic [2:0] LAST_IDX = 3'd5;
  localparam logic [3:0] GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  state_e             state_q, state_d;
  logic [47:0]        shift_q, shift_d;
  logic [2:0]         idx_q,   idx_d;
  logic [3:0]         gap_q,   gap_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;

  // NOTE: every register updates with <= so all flops sample the same
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: all next-state signals get a hold default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: if (en && !fifo_empty) state_d = S_POP;
      S_POP:  state_d = S_CAP;
      S_CAP: begin
        // FIFO output register holds the popped entry during this cycle.
        shift_d = {fifo_src, fifo_dst, fifo_data};
        idx_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (tx_ready) begin
          shift_d = {shift_q[39:0], 8'h00};
          idx_d   = idx_q + 3'd1;
          if (idx_q == LAST_IDX) begin
            cnt_d   = cnt_q + 1'b1;
            gap_d   = '0;
            state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_IDLE;
        else                   gap_d   = gap_q + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode only registered state, so they are glitch-free and
  // drop together with the asynchronous reset.
  always_comb begin
    fifo_rd  = (state_q == S_POP);
    tx_valid = (state_q == S_SEND);
    tx_data  = tx_valid ? shift_q[47:40] : 8'h00;
    tx_sop   = tx_valid && (idx_q == 3'd0);
    tx_eop   = tx_valid && (idx_q == LAST_IDX);
    busy     = (state_q != S_IDLE);
    pkt_cnt  = cnt_q;
  end

endmodule

// File: tb/tb_sync_fifo_pkt_drain.sv
// Directed bench for sync_fifo_pkt_drain: a queue-based FIFO model feeds the
// DUT, and a link monitor records every accepted byte with its cycle number.
module tb_sync_fifo_pkt_drain;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_src  = 8'h00;
  logic [7:0]  fifo_dst  = 8'h00;
  logic [31:0] fifo_data = 32'h0;
  logic        fifo_rd;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_sop, tx_eop;
  logic        tx_ready;
  logic [15:0] pkt_cnt;
  logic        busy;

  logic        w2_fifo_rd, w2_tx_valid, w2_tx_sop, w2_tx_eop, w2_busy;
  logic [7:0]  w2_tx_data;
  logic [1:0]  w2_pkt_cnt;

  logic        wr_en = 1'b0;
  logic [47:0] wr_data = '0;

  logic [47:0] fifo_q[$];
  logic [9:0]  rx_q[$];
  int          rx_cyc[$];
  int          cyc = 0;
  int          rd_cnt = 0;
  int          rd_empty_err = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  sync_fifo_pkt_drain #(.GAP_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .en(en), .fifo_empty(fifo_empty),
    .fifo_src(fifo_src), .fifo_dst(fifo_dst), .fifo_data(fifo_data),
    .fifo_rd(fifo_rd), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_ready(tx_ready),
    .pkt_cnt(pkt_cnt), .busy(busy)
  );

  // Narrow-counter copy shares every input; only its pkt_cnt is checked.
  sync_fifo_pkt_drain #(.GAP_CYCLES(2), .CNT_W(2)) dut_w2 (
    .clk(clk), .rstn(rstn), .en(en), .fifo_empty(fifo_empty),
    .fifo_src(fifo_src), .fifo_dst(fifo_dst), .fifo_data(fifo_data),
    .fifo_rd(w2_fifo_rd), .tx_data(w2_tx_data), .tx_valid(w2_tx_valid),
    .tx_sop(w2_tx_sop), .tx_eop(w2_tx_eop), .tx_ready(tx_ready),
    .pkt_cnt(w2_pkt_cnt), .busy(w2_busy)
  );

  // FIFO model with registered outputs plus link monitor.
  always @(posedge clk) begin
    logic [47:0] tmp;
    cyc = cyc + 1;
    if (rstn && tx_valid && tx_ready) begin
      rx_q.push_back({tx_sop, tx_eop, tx_data});
      rx_cyc.push_back(cyc);
    end
    if (rstn && fifo_rd) begin
      rd_cnt = rd_cnt + 1;
      if (fifo_q.size() == 0) rd_empty_err = rd_empty_err + 1;
      else begin
        tmp = fifo_q.pop_front();
        {fifo_src, fifo_dst, fifo_data} <= tmp;
      end
    end
    if (wr_en) fifo_q.push_back(wr_data);
    fifo_empty <= (fifo_q.size() == 0);
  end

  task automatic check(input string tag, input logic [47:0] act, input logic [47:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [47:0] e);
    wr_en   = 1'b1;
    wr_data = e;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("byte_timeout", 48'(rx_q.size() >= n), 48'd1);
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (!tx_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("valid_timeout", 48'(tx_valid), 48'd1);
  endtask

  function automatic logic [9:0] exp_byte(input logic [47:0] e, input int i);
    return {i == 0, i == 5, e[47-8*i -: 8]};
  endfunction

  task automatic check_pkt(input string tag, input int base, input logic [47:0] e);
    for (int i = 0; i < 6; i++)
      check(tag, 48'((base + i < rx_q.size()) ? rx_q[base+i] : 10'h3ff), 48'(exp_byte(e, i)));
  endtask

  localparam logic [47:0] P0 = {8'hA5, 8'h3C, 32'hDEADBEEF};
  localparam logic [47:0] P1 = {8'h11, 8'h22, 32'h33445566};
  localparam logic [47:0] P2 = {8'h77, 8'h88, 32'h99AABBCC};
  localparam logic [47:0] P3 = {8'h01, 8'hFE, 32'h0F0F0F0F};

  initial begin
    int k, base, rd0, cnt_exp[5];
    cnt_exp = '{1, 2, 3, 0, 1};
    rstn = 1'b0; en = 1'b0; tx_ready = 1'b0;
    #1;
    check("rst_state", {tx_valid, tx_sop, tx_eop, fifo_rd, busy}, '0);
    check("rst_data", 48'(tx_data), 48'h00);
    check("rst_cnt", 48'(pkt_cnt), 48'd0);
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Single packet, ready tied high, with first-byte latency.
    en = 1'b1; tx_ready = 1'b1;
    k = cyc;
    push(P0);
    wait_bytes(6, 40);
    check_pkt("single_byte", 0, P0);
    check("single_latency", 48'(rx_cyc[0] - k), 48'd5);
    check("single_consec", 48'(rx_cyc[5] - rx_cyc[0]), 48'd5);
    repeat (4) @(negedge clk);
    check("single_rd", 48'(rd_cnt), 48'd1);
    check("single_cnt", 48'(pkt_cnt), 48'd1);
    check("single_idle", 48'(busy), 48'd0);

    // Backpressure on byte 2 for four cycles.
    base = rx_q.size();
    push(P0);
    k = 0;
    while (!(tx_valid && tx_data == 8'hDE) && k < 30) begin
      @(negedge clk);
      k++;
    end
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_hold", {tx_valid, tx_sop, tx_eop, tx_data}, {3'b100, 8'hDE});
    end
    tx_ready = 1'b1;
    wait_bytes(base + 6, 40);
    repeat (6) @(negedge clk);
    check("bp_count", 48'(rx_q.size()), 48'(base + 6));
    check_pkt("bp_byte", base, P0);
    check("bp_cnt", 48'(pkt_cnt), 48'd2);

    // Three queued entries back to back.
    base = rx_q.size();
    rd0  = rd_cnt;
    push(P1); push(P2); push(P3);
    wait_bytes(base + 18, 200);
    check_pkt("b2b_p1", base, P1);
    check_pkt("b2b_p2", base + 6, P2);
    check_pkt("b2b_p3", base + 12, P3);
    for (int p = 1; p < 3; p++) begin
      check("b2b_period", 48'(rx_cyc[base+6*p] - rx_cyc[base+6*p-6]), 48'd11);
      check("b2b_eop_sop", 48'(rx_cyc[base+6*p] - rx_cyc[base+6*p-1]), 48'd6);
    end
    repeat (6) @(negedge clk);
    check("b2b_rd", 48'(rd_cnt - rd0), 48'd3);
    check("b2b_cnt", 48'(pkt_cnt), 48'd5);

    // en low blocks pops; en dropped mid-packet lets that packet finish.
    en  = 1'b0;
    rd0 = rd_cnt;
    base = rx_q.size();
    push(P2); push(P1);
    repeat (10) @(negedge clk);
    check("en0_rd", 48'(rd_cnt - rd0), 48'd0);
    check("en0_busy", 48'(busy), 48'd0);
    en = 1'b1;
    wait_valid(20);
    en = 1'b0;
    wait_bytes(base + 6, 40);
    repeat (15) @(negedge clk);
    check_pkt("en_drop_byte", base, P2);
    check("en_drop_rd", 48'(rd_cnt - rd0), 48'd1);
    check("en_drop_busy", 48'(busy), 48'd0);
    check("en_drop_left", 48'(fifo_empty), 48'd0);
    check("en_drop_cnt", 48'(pkt_cnt), 48'd6);
    en = 1'b1;
    wait_bytes(base + 12, 40);
    check_pkt("en_resume_byte", base + 6, P1);
    check("en_resume_cnt", 48'(pkt_cnt), 48'd7);

    // Asynchronous reset in the middle of SEND.
    @(negedge clk);
    push(P3);
    wait_valid(20);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_state", {tx_valid, fifo_rd, busy}, 3'b000);
    check("mid_rst_cnt", 48'(pkt_cnt), 48'd0);
    check("mid_rst_w2cnt", 48'(w2_pkt_cnt), 48'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", {tx_valid, busy}, 2'b00);

    // Narrow counter wraps 1,2,3,0,1.
    base = rx_q.size();
    push(P0); push(P1); push(P2); push(P3); push(P0);
    for (int p = 0; p < 5; p++) begin
      wait_bytes(base + 6 * (p + 1), 100);
      check("wrap_cnt", 48'(w2_pkt_cnt), 48'(cnt_exp[p]));
    end
    check("wrap_wide_cnt", 48'(pkt_cnt), 48'd5);
    repeat (6) @(negedge clk);
    check("rd_when_empty", 48'(rd_empty_err), 48'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
